audio_pwm_capture: RTL and testbench

- Decodes a single-bit audio PWM stream back into 10-bit samples. It is the receive-side counterpart of the audio PWM DAC.
- Each frame is delimited by rising edges of the sampling clock. The block counts `clk` cycles of PWM-low from frame start to the first PWM-high, and emits that count as the sample with a one-cycle valid strobe.
- Used for loopback self-test of the FM demod audio path, and for capturing external PWM audio into the same 10-bit sample domain.

---
 rtl/audio_pwm_capture.sv | 133 +++++++++++++
 tb/tb_audio_pwm_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_capture.sv
// audio_pwm_capture
// Receive-side decoder for the single-bit audio PWM stream. Each frame is
// bounded by rising edges of the sampling clock. The decoder measures how many
// clk cycles the PWM stays low after the frame edge, and reports that count as
// a DATA_W-bit sample together with qualifier flags.

module audio_pwm_capture #(
  parameter int DATA_W    = 10,
  parameter int CNT_W     = 12,
  parameter int MIN_FRAME = 16
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              frame_clk_in,
  input  logic              pwm_in,
  input  logic              capture_en,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              sample_sat,
  output logic              glitch,
  output logic              frame_err,
  output logic              busy
);

  localparam int               SAT_VAL = (1 << DATA_W) - 1;
  localparam logic [CNT_W-1:0] SAT_CNT = SAT_VAL[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MIN_CNT = MIN_FRAME[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       frame_sync;
  logic [1:0]       pwm_sync;
  logic             frame_prev;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic             glitch_pend;
  logic             fe;
  logic             pwm_s;

  // Both async inputs share the same synchronizer depth so that a PWM
  // transition launched together with a frame edge stays in the same cycle.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      frame_sync <= '0;
      pwm_sync   <= '0;
      frame_prev <= 1'b0;
    end else begin
      frame_sync <= {frame_sync[0], frame_clk_in};
      pwm_sync   <= {pwm_sync[0], pwm_in};
      frame_prev <= frame_sync[1];
    end
  end

  assign fe    = frame_sync[1] & ~frame_prev;
  assign pwm_s = pwm_sync[1];
  assign busy  = (state == LOW) || (state == HIGH);

  // Frame FSM: measures low time, commits the finished frame on each edge and
  // immediately starts the next frame so consecutive frames have no gap.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state        <= IDLE;
      low_cnt      <= '0;
      frame_cnt    <= '0;
      glitch_pend  <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sample_sat   <= 1'b0;
      glitch       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sample_sat   <= 1'b0;
      glitch       <= 1'b0;
      frame_err    <= 1'b0;
      if (!capture_en) begin
        state       <= IDLE;
        low_cnt     <= '0;
        frame_cnt   <= '0;
        glitch_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (fe) begin
              state       <= pwm_s ? HIGH : LOW;
              low_cnt     <= '0;
              frame_cnt   <= '0;
              glitch_pend <= 1'b0;
            end
          end
          LOW, HIGH: begin
            if (fe) begin
              if (frame_cnt < MIN_CNT) begin
                frame_err <= 1'b1;
              end else begin
                sample_valid <= 1'b1;
                glitch       <= glitch_pend;
                if ((state == LOW) || (low_cnt >= SAT_CNT)) begin
                  sample_sat <= 1'b1;
                  sample_out <= '1;
                end else begin
                  sample_out <= low_cnt[DATA_W-1:0];
                end
              end
              state       <= pwm_s ? HIGH : LOW;
              low_cnt     <= '0;
              frame_cnt   <= '0;
              glitch_pend <= 1'b0;
            end else begin
              if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + 1'b1;
              if (state == LOW) begin
                if (pwm_s) state <= HIGH;
                else if (low_cnt != CNT_MAX) low_cnt <= low_cnt + 1'b1;
              end else if (!pwm_s) begin
                glitch_pend <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_capture.sv
// tb_audio_pwm_capture
// Directed bench for the PWM capture block. Frames are driven cycle by cycle;
// each frame's expected sample is pushed to a queue when the edge that
// commits it is driven, and a monitor pops and compares on every strobe.

module tb_audio_pwm_capture;

  localparam int MIN_FRAME = 16;

  typedef struct {
    logic [9:0] sample;
    logic       glitch;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       frame_clk_in;
  logic       pwm_in;
  logic       capture_en;
  logic [9:0] sample_out;
  logic       sample_valid;
  logic       sample_sat;
  logic       glitch;
  logic       frame_err;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_edge_cyc = 0;
  int   strobes = 0;
  int   exp_strobes = 0;
  int   err_pulses = 0;
  int   exp_err = 0;
  int   strobes_at_reset = 0;
  exp_t q[$];
  exp_t pend_exp;
  exp_t mon_exp;
  bit   pend_valid = 1'b0;
  bit   pend_short = 1'b0;

  audio_pwm_capture #(.DATA_W(10), .CNT_W(12), .MIN_FRAME(MIN_FRAME)) dut (
    .clk          (clk),
    .RSTn         (RSTn),
    .frame_clk_in (frame_clk_in),
    .pwm_in       (pwm_in),
    .capture_en   (capture_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_sat   (sample_sat),
    .glitch       (glitch),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // PWM level at frame index i: low for low1, high for high1, low for low2, then high.
  function automatic logic pwm_at(input int i, input int low1, input int high1, input int low2);
    if (i < low1) return 1'b0;
    if (i < low1 + high1) return 1'b1;
    if (i < low1 + high1 + low2) return 1'b0;
    return 1'b1;
  endfunction

  // Reference decode: index 0 is the edge cycle, which is never counted.
  function automatic exp_t model(input int len, input int low1, input int high1, input int low2);
    exp_t e;
    int   counted;
    e.glitch = (low1 < len) && (low2 > 0) && (low1 + high1 < len);
    if (low1 >= len) begin
      e.sat    = 1'b1;
      e.sample = 10'h3FF;
    end else begin
      counted = (low1 > 0) ? low1 - 1 : 0;
      if (counted >= 1023) begin
        e.sat    = 1'b1;
        e.sample = 10'h3FF;
      end else begin
        e.sat    = 1'b0;
        e.sample = 10'(counted);
      end
    end
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Drives one frame; its leading edge commits whatever frame preceded it.
  task automatic apply_stimulus(input int len, input int low1, input int high1, input int low2,
                                input bit report, input int abort_at);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        last_edge_cyc = cyc;
        if (pend_valid) begin
          if (pend_short) exp_err++;
          else begin
            q.push_back(pend_exp);
            exp_strobes++;
          end
        end
        pend_valid = report;
        pend_short = (len - 1) < MIN_FRAME;
        pend_exp   = model(len, low1, high1, low2);
      end
      if (i == abort_at) capture_en = 1'b0;
      frame_clk_in = (i < len / 2);
      pwm_in       = pwm_at(i, low1, high1, low2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_sample"}, sample_out, 0);
    check_output({tag, "_valid"}, sample_valid, 0);
    check_output({tag, "_sat"}, sample_sat, 0);
    check_output({tag, "_glitch"}, glitch, 0);
    check_output({tag, "_frame_err"}, frame_err, 0);
    check_output({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    RSTn         = 1'b0;
    capture_en   = 1'b0;
    frame_clk_in = 1'b0;
    pwm_in       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    RSTn = 1'b1;

    // Strobe monitor: sampled on the falling edge, away from register updates.
    fork
      forever begin
        @(negedge clk);
        if (frame_err) err_pulses++;
        if (sample_valid) begin
          strobes++;
          check_output("strobe_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            mon_exp = q.pop_front();
            check_output("sample", sample_out, mon_exp.sample);
            check_output("glitch", glitch, mon_exp.glitch);
            check_output("sat", sample_sat, mon_exp.sat);
            check_output("latency", cyc - last_edge_cyc, 3);
          end
        end else begin
          check_output("flags_idle", {glitch, sample_sat}, 0);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_output("busy_idle", busy, 0);
    capture_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("busy_arm", busy, 0);

    // Steady frames: 300 low, all low, all high, glitch, 300 low again.
    apply_stimulus(1200, 301, 899, 0, 1'b1, -1);
    check_output("busy_frame", busy, 1);
    apply_stimulus(1200, 301, 899, 0, 1'b1, -1);
    apply_stimulus(1200, 1200, 0, 0, 1'b1, -1);
    apply_stimulus(1200, 0, 1200, 0, 1'b1, -1);
    apply_stimulus(1200, 501, 100, 10, 1'b1, -1);
    apply_stimulus(1200, 301, 899, 0, 1'b1, -1);

    // Three frames only 10 clk long must be discarded.
    apply_stimulus(10, 3, 7, 0, 1'b1, -1);
    apply_stimulus(10, 3, 7, 0, 1'b1, -1);
    apply_stimulus(10, 3, 7, 0, 1'b1, -1);
    apply_stimulus(1200, 201, 999, 0, 1'b1, -1);
    check_output("sample_held", sample_out, 300);
    check_output("err_pulses", err_pulses, exp_err);

    // Drop enable mid-frame, then reset mid-frame.
    apply_stimulus(1200, 301, 899, 0, 1'b0, 400);
    check_output("busy_dropped", busy, 0);
    check_output("sample_after_drop", sample_out, 200);
    RSTn = 1'b0;
    #2;
    check_all_zero("midreset");
    strobes_at_reset = strobes;
    pend_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    RSTn       = 1'b1;
    capture_en = 1'b1;
    repeat (4) @(posedge clk);

    // After re-enable the first edge only arms; its frame reports at the second edge.
    apply_stimulus(1200, 401, 799, 0, 1'b1, -1);
    check_output("no_strobe_first_fe", strobes, strobes_at_reset);
    apply_stimulus(1200, 0, 1200, 0, 1'b1, -1);
    apply_stimulus(40, 11, 29, 0, 1'b1, -1);

    check_output("queue_drained", q.size(), 0);
    check_output("strobe_count", strobes, exp_strobes);
    check_output("frame_err_count", err_pulses, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
